// File: rtl/fifo_to_axi.sv
// fifo_to_axi: packet FIFO + metadata FIFO to AXI-Stream master; optional packet counter under FIFO_TO_AXI_PKT_CNT_EN
module fifo_to_axi (
  input  logic         clk,
  input  logic         reset,
  output logic         fifo_rden,
  input  logic         fifo_empty,
  input  logic [288:0] fifo_dout,
  output logic         meta_rden,
  input  logic         meta_empty,
  input  logic [127:0] meta_dout,
  output logic         tvalid,
  input  logic         tready,
  output logic [255:0] tdata,
  output logic [31:0]  tstrb,
  output logic         tlast,
  output logic [127:0] tuser,
  output logic [31:0]  output_pkt_cnt
);
  typedef enum logic [1:0] {IDLE, META, PKT} state_t;
  state_t r_state, w_next;
  logic [288:0] r_b0, r_b1, r_b2;
  logic [1:0] r_occ, w_widx;
  logic r_infl, r_last_read, w_last_seen, w_pop, w_push, w_eop;
  logic [127:0] r_tuser;
  // read strobes, stream handshake and next state; a tlast word coming back this cycle blocks further reads immediately
  always_comb begin
    w_push = r_infl;
    w_pop = tvalid & tready;
    w_eop = w_pop & r_b0[288];
    w_widx = r_occ - {1'b0, w_pop};
    w_last_seen = r_last_read | (r_infl & fifo_dout[288]);
    meta_rden = !reset && r_state == IDLE && !meta_empty;
    tvalid = !reset && r_state == PKT && r_occ != 2'd0;
    fifo_rden = !reset && r_state == PKT && !fifo_empty && !w_last_seen &&
                ({1'b0, r_occ} + {2'b0, r_infl} < 3'd3);
    w_next = r_state == IDLE ? (meta_rden ? META : IDLE) :
             r_state == META ? PKT : (w_eop ? IDLE : PKT);
    tdata = r_b0[255:0];
    tstrb = r_b0[287:256];
    tlast = r_b0[288];
    tuser = r_tuser;
  end
  // state, occupancy, in-flight flag, last-read flag and captured metadata
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_next;
    r_occ <= reset ? 2'd0 : r_occ + {1'b0, w_push} - {1'b0, w_pop};
    r_infl <= reset ? 1'b0 : fifo_rden;
    r_last_read <= reset ? 1'b0 : w_eop ? 1'b0 : (w_push & fifo_dout[288]) ? 1'b1 : r_last_read;
    r_tuser <= reset ? '0 : r_state == META ? meta_dout : r_tuser;
  end
  // 3-entry shifting skid buffer: pop shifts toward the head, returned word lands after the survivors
  always_ff @(posedge clk) begin
    r_b0 <= (w_push && w_widx == 2'd0) ? fifo_dout : w_pop ? r_b1 : r_b0;
    r_b1 <= (w_push && w_widx == 2'd1) ? fifo_dout : w_pop ? r_b2 : r_b1;
    r_b2 <= (w_push && w_widx == 2'd2) ? fifo_dout : r_b2;
  end
`ifdef FIFO_TO_AXI_PKT_CNT_EN
  logic [31:0] r_cnt;
  // completed-packet counter, wraps naturally
  always_ff @(posedge clk) begin
    r_cnt <= reset ? '0 : r_cnt + {31'b0, w_eop};
  end
  assign output_pkt_cnt = r_cnt;
`else
  assign output_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_to_axi.sv
// tb_fifo_to_axi: directed self-checking bench for fifo_to_axi
module tb_fifo_to_axi;
`ifdef FIFO_TO_AXI_PKT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 0, reset = 1, tready = 0, flush = 0;
  logic fifo_rden, fifo_empty, meta_rden, meta_empty, tvalid, tlast;
  logic [288:0] fifo_dout = '0;
  logic [127:0] meta_dout = '0, tuser;
  logic [255:0] tdata;
  logic [31:0] tstrb, output_pkt_cnt;

  fifo_to_axi dut (
    .clk(clk), .reset(reset), .fifo_rden(fifo_rden), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .meta_rden(meta_rden), .meta_empty(meta_empty), .meta_dout(meta_dout), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tstrb(tstrb), .tlast(tlast), .tuser(tuser), .output_pkt_cnt(output_pkt_cnt)
  );

  always #5 clk = ~clk;

  logic [288:0] dmem [0:63];
  logic [127:0] mmem [0:15];
  int dwp = 0, drp = 0, mwp = 0, mrp = 0;
  assign fifo_empty = drp == dwp;
  assign meta_empty = mrp == mwp;

  always @(posedge clk) begin
    if (flush) drp <= dwp;
    else if (fifo_rden) begin
      fifo_dout <= dmem[drp];
      drp <= drp + 1;
    end
    if (meta_rden) begin
      meta_dout <= mmem[mrp];
      mrp <= mrp + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] bt_data [0:63];
  logic [127:0] bt_user [0:63];
  logic [31:0] bt_strb [0:63];
  logic bt_last [0:63];
  int bt_cyc [0:63];
  int mr_cyc [0:15], mr_rd [0:15];
  int nb = 0, nm = 0, rdc = 0, bc = 0, rd_tot = 0, ovf_err = 0, stab_err = 0;
  logic p_v = 0, p_r = 0;
  logic [416:0] p_pay = '0;

  always @(negedge clk) begin
    if (reset) begin
      rdc = 0;
      bc = 0;
      p_v = 0;
    end else begin
      if (fifo_rden && rdc - bc >= 3) ovf_err++;
      if (fifo_rden) begin
        rdc++;
        rd_tot++;
      end
      if (p_v && !p_r && (!tvalid || {tdata, tstrb, tlast, tuser} !== p_pay)) stab_err++;
      if (meta_rden) begin
        mr_cyc[nm] = cyc;
        mr_rd[nm] = rd_tot;
        nm++;
      end
      if (tvalid && tready) begin
        bt_data[nb] = tdata;
        bt_user[nb] = tuser;
        bt_strb[nb] = tstrb;
        bt_last[nb] = tlast;
        bt_cyc[nb] = cyc;
        nb++;
        bc++;
      end
      p_v = tvalid;
      p_r = tready;
      p_pay = {tdata, tstrb, tlast, tuser};
    end
  end

  int ncmp = 0, nerr = 0, base = 0, exp_pkts = 0;

  task automatic push_data(input logic last, input logic [255:0] d);
    dmem[dwp] = {last, 32'hFFFFFFFF, d};
    dwp++;
  endtask

  task automatic push_meta(input logic [127:0] m);
    mmem[mwp] = m;
    mwp++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input bit tog);
    int t = 0;
    while (nb < base + n && t < 200) begin
      step(1);
      if (tog) tready = !tready;
      t++;
    end
    ncmp++;
    if (nb < base + n) begin
      nerr++;
      $display("FAIL beat_timeout got %0d beats want %0d", nb - base, n);
    end
  endtask

  task automatic check_cnt(input string nm_s);
    logic [31:0] e;
    e = CNT_EN ? exp_pkts : 0;
    ncmp++;
    if (output_pkt_cnt !== e) begin
      nerr++;
      $display("FAIL %s pkt_cnt got %0d want %0d", nm_s, output_pkt_cnt, e);
    end
  endtask

  task automatic test_reset();
    push_meta(128'hA5);
    push_data(1'b1, 256'd7);
    step(2);
    @(negedge clk);
    ncmp += 5;
    if (tvalid !== 1'b0) begin nerr++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    if (fifo_rden !== 1'b0) begin nerr++; $display("FAIL reset_fifo_rden got %b want 0", fifo_rden); end
    if (meta_rden !== 1'b0) begin nerr++; $display("FAIL reset_meta_rden got %b want 0", meta_rden); end
    if (tuser !== 128'd0) begin nerr++; $display("FAIL reset_tuser got %0h want 0", tuser); end
    if (output_pkt_cnt !== 32'd0) begin nerr++; $display("FAIL reset_pkt_cnt got %0d want 0", output_pkt_cnt); end
    step(1);
    reset = 0;
    tready = 1;
  endtask

  task automatic test_single_beat();
    base = nb;
    exp_pkts = 1;
    wait_beats(1, 0);
    step(4);
    ncmp += 6;
    if (nb - base !== 1) begin nerr++; $display("FAIL single_count got %0d want 1", nb - base); end
    if (bt_data[base] !== 256'd7) begin nerr++; $display("FAIL single_tdata got %0h want 7", bt_data[base]); end
    if (bt_last[base] !== 1'b1) begin nerr++; $display("FAIL single_tlast got %b want 1", bt_last[base]); end
    if (bt_strb[base] !== 32'hFFFFFFFF) begin nerr++; $display("FAIL single_tstrb got %0h want ffffffff", bt_strb[base]); end
    if (bt_user[base] !== 128'hA5) begin nerr++; $display("FAIL single_tuser got %0h want a5", bt_user[base]); end
    if (bt_cyc[base] - mr_cyc[nm-1] !== 4) begin nerr++; $display("FAIL single_latency got %0d want 4", bt_cyc[base] - mr_cyc[nm-1]); end
    check_cnt("single");
  endtask

  task automatic test_four_beat(input bit tog);
    int mb;
    base = nb;
    mb = nm;
    stab_err = 0;
    ovf_err = 0;
    for (int i = 1; i <= 4; i++) push_data(i == 4, 256'(i));
    push_meta(tog ? 128'h55 : 128'h44);
    tready = tog ? 1'b0 : 1'b1;
    wait_beats(4, tog);
    tready = 1;
    step(4);
    exp_pkts++;
    ncmp++;
    if (nb - base !== 4) begin nerr++; $display("FAIL four_count got %0d want 4", nb - base); end
    for (int i = 0; i < 4; i++) begin
      ncmp += 3;
      if (bt_data[base+i] !== 256'(i + 1)) begin nerr++; $display("FAIL four_tdata%0d got %0h want %0h", i, bt_data[base+i], i + 1); end
      if (bt_last[base+i] !== (i == 3)) begin nerr++; $display("FAIL four_tlast%0d got %b want %b", i, bt_last[base+i], i == 3); end
      if (bt_user[base+i] !== (tog ? 128'h55 : 128'h44)) begin nerr++; $display("FAIL four_tuser%0d got %0h", i, bt_user[base+i]); end
    end
    if (!tog) begin
      ncmp++;
      if (bt_cyc[base] - mr_cyc[mb] !== 4) begin nerr++; $display("FAIL four_latency got %0d want 4", bt_cyc[base] - mr_cyc[mb]); end
      for (int i = 1; i < 4; i++) begin
        ncmp++;
        if (bt_cyc[base+i] !== bt_cyc[base] + i) begin nerr++; $display("FAIL four_consecutive%0d got %0d want %0d", i, bt_cyc[base+i], bt_cyc[base] + i); end
      end
    end else begin
      ncmp += 2;
      if (stab_err !== 0) begin nerr++; $display("FAIL toggle_stable got %0d violations want 0", stab_err); end
      if (ovf_err !== 0) begin nerr++; $display("FAIL toggle_overflow got %0d violations want 0", ovf_err); end
    end
    check_cnt(tog ? "toggle" : "four");
  endtask

  task automatic test_back_to_back();
    int mb, rb;
    base = nb;
    mb = nm;
    rb = rd_tot;
    push_data(1'b0, 256'hA1);
    push_data(1'b1, 256'hA2);
    push_data(1'b0, 256'hB1);
    push_data(1'b1, 256'hB2);
    push_meta(128'hAAAA);
    push_meta(128'hBBBB);
    wait_beats(4, 0);
    step(4);
    exp_pkts += 2;
    for (int i = 0; i < 4; i++) begin
      logic [255:0] ed;
      logic [127:0] eu;
      ed = i == 0 ? 256'hA1 : i == 1 ? 256'hA2 : i == 2 ? 256'hB1 : 256'hB2;
      eu = i < 2 ? 128'hAAAA : 128'hBBBB;
      ncmp += 2;
      if (bt_data[base+i] !== ed) begin nerr++; $display("FAIL b2b_tdata%0d got %0h want %0h", i, bt_data[base+i], ed); end
      if (bt_user[base+i] !== eu) begin nerr++; $display("FAIL b2b_tuser%0d got %0h want %0h", i, bt_user[base+i], eu); end
    end
    ncmp += 2;
    if (mr_rd[mb+1] - rb !== 2) begin nerr++; $display("FAIL b2b_early_read got %0d reads want 2", mr_rd[mb+1] - rb); end
    if (mr_cyc[mb+1] <= bt_cyc[base+1]) begin nerr++; $display("FAIL b2b_gap got meta cycle %0d want > %0d", mr_cyc[mb+1], bt_cyc[base+1]); end
    check_cnt("b2b");
  endtask

  task automatic test_reset_mid();
    int t = 0;
    base = nb;
    for (int i = 1; i <= 4; i++) push_data(i == 4, 256'(16 + i));
    push_meta(128'h33);
    while (nb < base + 2 && t < 200) begin
      step(1);
      t++;
    end
    tready = 0;
    reset = 1;
    step(1);
    reset = 0;
    flush = 1;
    exp_pkts = 0;
    @(negedge clk);
    ncmp += 3;
    if (tvalid !== 1'b0) begin nerr++; $display("FAIL rstmid_tvalid got %b want 0", tvalid); end
    if (nb - base !== 2) begin nerr++; $display("FAIL rstmid_beats got %0d want 2", nb - base); end
    if (output_pkt_cnt !== 32'd0) begin nerr++; $display("FAIL rstmid_pkt_cnt got %0d want 0", output_pkt_cnt); end
    step(1);
    flush = 0;
    step(1);
    base = nb;
    tready = 1;
    push_data(1'b1, 256'h9);
    push_meta(128'hCC);
    wait_beats(1, 0);
    step(4);
    exp_pkts = 1;
    ncmp += 4;
    if (nb - base !== 1) begin nerr++; $display("FAIL rstmid_next_count got %0d want 1", nb - base); end
    if (bt_data[base] !== 256'h9) begin nerr++; $display("FAIL rstmid_next_tdata got %0h want 9", bt_data[base]); end
    if (bt_user[base] !== 128'hCC) begin nerr++; $display("FAIL rstmid_next_tuser got %0h want cc", bt_user[base]); end
    if (bt_last[base] !== 1'b1) begin nerr++; $display("FAIL rstmid_next_tlast got %b want 1", bt_last[base]); end
    check_cnt("rstmid");
  endtask

  task automatic test_pkt_count();
    base = nb;
    for (int i = 0; i < 3; i++) begin
      push_data(1'b1, 256'(32'h21 + i));
      push_meta(128'(32'h70 + i));
    end
    for (int i = 0; i < 3; i++) begin
      wait_beats(i + 1, 0);
      step(1);
      exp_pkts++;
      check_cnt("count");
    end
    step(4);
    for (int i = 0; i < 3; i++) begin
      ncmp += 2;
      if (bt_data[base+i] !== 256'(32'h21 + i)) begin nerr++; $display("FAIL count_tdata%0d got %0h want %0h", i, bt_data[base+i], 32'h21 + i); end
      if (bt_user[base+i] !== 128'(32'h70 + i)) begin nerr++; $display("FAIL count_tuser%0d got %0h want %0h", i, bt_user[base+i], 32'h70 + i); end
    end
  endtask

  initial begin
    step(1);
    test_reset();
    test_single_beat();
    test_four_beat(0);
    test_four_beat(1);
    test_back_to_back();
    test_reset_mid();
    test_pkt_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_to_axi.md
FIFO_TO_AXI -- requirements
Module: fifo_to_axi

Interface
REQ-001 SHALL have ports: clk  in  1  single clock for all logic; synchronous reset, active-high, sampled on posedge clk.
REQ-002 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: fifo_rden  out  1 and fifo_empty  in  1, the data-FIFO read strobe and empty flag.
REQ-004 SHALL have port fifo_dout  in  289  data-FIFO word {tlast[288], tstrb[287:256], tdata[255:0]}, valid exactly 1 cycle after fifo_rden.
REQ-005 SHALL have ports: meta_rden  out  1, meta_empty  in  1, meta_dout  in  128  per-packet metadata FIFO, data valid 1 cycle after meta_rden.
REQ-006 SHALL have AXI-Stream master ports: tvalid out 1, tready in 1, tdata out 256, tstrb out 32, tlast out 1, tuser out 128.
REQ-007 SHALL have port output_pkt_cnt  out  32  count of completed packets (see Configuration).

Function
REQ-008 SHALL implement states IDLE, META, PKT.
REQ-009 IDLE: meta_rden = !meta_empty (combinational); when asserted, next state META; otherwise stay in IDLE.
REQ-010 META: capture meta_dout into tuser register; next state PKT unconditionally.
REQ-011 PKT: tuser SHALL hold its captured value on every beat of the packet.
REQ-012 SHALL buffer returned FIFO words in a 3-entry skid buffer; tdata/tstrb/tlast are driven from the buffer head.
REQ-013 fifo_rden = (state==PKT) & !fifo_empty & !last_read & (occupancy + inflight < 3); inflight is 1 in the cycle after fifo_rden, else 0.
REQ-014 fifo_rden SHALL NOT depend combinationally on tready.
REQ-015 last_read SHALL be set when a word returned with bit 288 = 1; no further reads occur until the next packet.
REQ-016 tvalid = (state==PKT) & (occupancy > 0); once asserted, tvalid and payload SHALL stay stable until tvalid & tready.
REQ-017 A beat transfers when tvalid & tready; buffer pop and FIFO-return push in the same cycle SHALL leave occupancy unchanged.
REQ-018 Acceptance of a beat with tlast=1 SHALL clear last_read and move the state to IDLE on the next cycle.
REQ-019 With continuous tready=1 and a non-empty FIFO, SHALL sustain 1 beat per cycle after the first beat.
REQ-020 Latency: meta_rden at cycle 0 with data FIFO non-empty -> first tvalid=1 at cycle 4.
REQ-021 Minimum gap: tlast accepted at cycle n -> meta_rden no earlier than cycle n+1.
REQ-022 fifo_empty rising mid-packet SHALL stall reads; tvalid falls only after the buffer drains and only between beats.
REQ-023 The buffer SHALL never overflow; a returned word always has a free entry by construction (REQ-013).

Reset
REQ-024 While reset=1: state=IDLE, occupancy=0, inflight discarded, last_read=0, tvalid=0, fifo_rden=0, meta_rden=0, tuser=0, output_pkt_cnt=0.
REQ-025 Reset mid-packet SHALL abandon the packet; the word returned in the cycle after reset deasserts (from a pre-reset read) SHALL be dropped.

Configuration
REQ-026 Macro FIFO_TO_AXI_PKT_CNT_EN, when defined: output_pkt_cnt increments by 1 on each accepted tlast beat and wraps 0xFFFFFFFF->0.
REQ-027 When FIFO_TO_AXI_PKT_CNT_EN is undefined: output_pkt_cnt SHALL be constant 0 and no counter register is synthesized.

Verification
REQ-028 1-beat packet, meta=128'hA5, word {1,32'hFFFFFFFF,256'd7}, tready=1 -> single beat: tdata=7, tlast=1, tuser=A5; output_pkt_cnt=1 (macro on).
REQ-029 4-beat packet (tdata 1..4), tready=1 -> tvalid high 4 consecutive cycles starting 4 cycles after meta_rden; tlast only on tdata=4.
REQ-030 Same packet with tready toggling 1,0,1,0 -> each beat held stable while tready=0; fifo_rden never issued with occupancy+inflight=3; no loss or duplication.
REQ-031 Two back-to-back packets (meta A, B; 2 beats each) -> tuser=A on beats 1-2, tuser=B on beats 3-4; no read of packet B's data before B's META state.
REQ-032 reset pulsed for 1 cycle after beat 2 of a 4-beat packet -> tvalid=0 next cycle; the next packet starts clean with output_pkt_cnt=0.
REQ-033 Macro undefined, 3 packets sent -> output_pkt_cnt=0 throughout.
